// File: rtl/pipeline_hazard_ctrl_pkg.sv
// definesPkg: hazard FSM state encoding and shared widths for pipeline_hazard_ctrl
package definesPkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } hazard_state_t;
  localparam int REG_AW_DEF = 3;
  localparam int FCNT_W     = 3;
  localparam int PERF_W     = 16;
endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counters.sv
// hazard_perf_counters: saturating stall-cycle and flush-event counters
module hazard_perf_counters
  import definesPkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_inc_i,
  input  logic         flush_inc_i,
  output logic [W-1:0] stall_cycles_o,
  output logic [W-1:0] flush_events_o
);
  logic [W-1:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    stall_q <= reset ? '0 : stall_q + W'(stall_inc_i && !(&stall_q));
    flush_q <= reset ? '0 : flush_q + W'(flush_inc_i && !(&flush_q));
  end
  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and dmem freeze control; HAZARD_PERF_EN adds perf counters
module pipeline_hazard_ctrl
  import definesPkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              br_taken,
  input  logic              dmem_wait,
  output logic              pc_write,
  output logic              pc_src,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        state,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);
  hazard_state_t     state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              load_use, frz, br, fl, lu;
  assign load_use = id_valid && ex_valid && ex_is_load &&
                    ((id_use_a && id_rs_a == ex_rd) || (id_use_b && id_rs_b == ex_rd));
  // a nonzero remaining count means a flush is in progress, even across a MEM_WAIT
  assign frz = dmem_wait;
  assign br  = !dmem_wait && br_taken;
  assign fl  = !dmem_wait && !br_taken && fcnt_q != '0;
  assign lu  = !dmem_wait && !br_taken && fcnt_q == '0 && load_use;
  assign pc_write     = !reset && !frz && !lu;
  assign if_id_write  = pc_write;
  assign pc_src       = !reset && br;
  assign if_id_flush  = reset || br || fl;
  assign id_ex_bubble = !reset && (br || lu);
  assign pipe_freeze  = !reset && frz;
  assign state        = reset ? RUN : state_q;
  always_comb begin
    state_d = frz ? MEM_WAIT
            : br  ? (FLUSH_CYCLES > 1 ? FLUSH : RUN)
            : fl  ? (fcnt_q == FCNT_W'(1) ? RUN : FLUSH)
            : lu  ? LOAD_STALL : RUN;
    fcnt_d  = br ? FCNT_W'(FLUSH_CYCLES - 1) : fl ? fcnt_q - 1'b1 : fcnt_q;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? RUN : state_d;
    fcnt_q  <= reset ? '0 : fcnt_d;
  end
`ifdef HAZARD_PERF_EN
  hazard_perf_counters #(.W(PERF_W)) u_perf (
    .clk            (clk),
    .reset          (reset),
    .stall_inc_i    (!pc_write),
    .flush_inc_i    (br),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2)
module tb_pipeline_hazard_ctrl;
  import definesPkg::*;
  typedef struct packed {
    logic [1:0] st;
    logic pw, ps, iw, fl, bb, fz;
  } exp_t;
  logic clk = 1'b0;
  logic reset, id_valid, id_use_a, id_use_b, ex_valid, ex_is_load, br_taken, dmem_wait;
  logic [2:0] id_rs_a, id_rs_b, ex_rd;
  logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [1:0] state;
  logic [15:0] stall_cycles, flush_events;
  int nchk = 0, nerr = 0;
  exp_t sb[$];
  logic [15:0] m_stall = '0, m_flush = '0;
  pipeline_hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .br_taken(br_taken), .dmem_wait(dmem_wait), .pc_write(pc_write),
    .pc_src(pc_src), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  always #5 clk = ~clk;
  function automatic exp_t ex(input hazard_state_t s, input logic [5:0] v);
    return {s, v};
  endfunction
  task automatic drv(input logic dw, input logic br, input logic lu);
    dmem_wait = dw; br_taken = br;
    id_valid = lu; ex_valid = lu; ex_is_load = lu; ex_rd = 3'd3;
    id_rs_a = 3'd3; id_use_a = lu; id_rs_b = 3'd5; id_use_b = 1'b0;
  endtask
  task automatic chk(input exp_t e, input string nm);
    exp_t got, x;
    sb.push_back(e);
    #2;
    got = {state, pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze};
    x = sb.pop_front();
    nchk++;
    if (got !== x) begin
      nerr++;
      $display("FAIL %s ctrl: got %b want %b (st,pw,ps,iw,fl,bb,fz)", nm, got, x);
    end
    nchk++;
    if (stall_cycles !== m_stall) begin
      nerr++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cycles, m_stall);
    end
    nchk++;
    if (flush_events !== m_flush) begin
      nerr++;
      $display("FAIL %s flush_events: got %0d want %0d", nm, flush_events, m_flush);
    end
`ifdef HAZARD_PERF_EN
    if (reset) begin
      m_stall = '0; m_flush = '0;
    end else begin
      if (!x.pw && m_stall != 16'hFFFF) m_stall++;
      if (x.ps && m_flush != 16'hFFFF) m_flush++;
    end
`endif
    @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b1; drv(1, 1, 1);
    chk(ex(RUN, 6'b000100), "reset_prio");
    drv(0, 0, 0);
    chk(ex(RUN, 6'b000100), "reset_idle");
    reset = 1'b0;
    chk(ex(RUN, 6'b101000), "run_idle");
  endtask
  task automatic test_load_use;
    drv(0, 0, 1);
    chk(ex(RUN, 6'b000010), "lu_stall");
    drv(0, 0, 0);
    chk(ex(LOAD_STALL, 6'b101000), "lu_onecycle");
    chk(ex(RUN, 6'b101000), "lu_back_run");
  endtask
  task automatic test_no_hazard;
    drv(0, 0, 1); id_use_a = 1'b0;
    chk(ex(RUN, 6'b101000), "nouse_a");
    drv(0, 0, 1); ex_is_load = 1'b0;
    chk(ex(RUN, 6'b101000), "not_load");
    drv(0, 0, 1); id_valid = 1'b0;
    chk(ex(RUN, 6'b101000), "id_invalid");
    drv(0, 0, 1); ex_valid = 1'b0;
    chk(ex(RUN, 6'b101000), "ex_invalid");
    drv(0, 0, 1); id_rs_a = 3'd4;
    chk(ex(RUN, 6'b101000), "rs_mismatch");
    drv(0, 0, 1); id_use_a = 1'b0; id_rs_b = 3'd3; id_use_b = 1'b1;
    chk(ex(RUN, 6'b000010), "rs_b_stall");
    drv(0, 0, 0);
    chk(ex(LOAD_STALL, 6'b101000), "rs_b_done");
    chk(ex(RUN, 6'b101000), "rs_b_run");
  endtask
  task automatic test_restall;
    drv(0, 0, 1);
    chk(ex(RUN, 6'b000010), "re_1");
    chk(ex(LOAD_STALL, 6'b000010), "re_2");
    drv(0, 0, 0);
    chk(ex(LOAD_STALL, 6'b101000), "re_3");
    chk(ex(RUN, 6'b101000), "re_4");
  endtask
  task automatic test_branch;
    drv(0, 1, 0);
    chk(ex(RUN, 6'b111110), "br_n");
    drv(0, 0, 0);
    chk(ex(FLUSH, 6'b101100), "br_n1");
    chk(ex(RUN, 6'b101000), "br_n2");
    drv(0, 1, 1);
    chk(ex(RUN, 6'b111110), "br_over_lu");
    drv(0, 0, 1);
    chk(ex(FLUSH, 6'b101100), "flush_ign_lu");
    drv(0, 0, 0);
    chk(ex(RUN, 6'b101000), "br2_run");
  endtask
  task automatic test_back_to_back;
    drv(0, 1, 0);
    chk(ex(RUN, 6'b111110), "b2b_1");
    chk(ex(FLUSH, 6'b111110), "b2b_restart");
    drv(0, 0, 0);
    chk(ex(FLUSH, 6'b101100), "b2b_flush");
    chk(ex(RUN, 6'b101000), "b2b_run");
  endtask
  task automatic test_dmem_branch;
    drv(1, 1, 0);
    chk(ex(RUN, 6'b000001), "dw_br_1");
    chk(ex(MEM_WAIT, 6'b000001), "dw_br_2");
    chk(ex(MEM_WAIT, 6'b000001), "dw_br_3");
    drv(0, 1, 0);
    chk(ex(MEM_WAIT, 6'b111110), "dw_br_rel");
    drv(0, 0, 0);
    chk(ex(FLUSH, 6'b101100), "dw_br_flush");
    chk(ex(RUN, 6'b101000), "dw_br_run");
  endtask
  task automatic test_dmem_in_flush;
    drv(0, 1, 0);
    chk(ex(RUN, 6'b111110), "dwf_br");
    drv(1, 0, 0);
    chk(ex(FLUSH, 6'b000001), "dwf_frz1");
    chk(ex(MEM_WAIT, 6'b000001), "dwf_frz2");
    drv(0, 0, 0);
    chk(ex(MEM_WAIT, 6'b101100), "dwf_resume");
    chk(ex(RUN, 6'b101000), "dwf_run");
  endtask
  task automatic test_dmem_load;
    drv(1, 0, 1);
    chk(ex(RUN, 6'b000001), "dwl_frz");
    drv(0, 0, 1);
    chk(ex(MEM_WAIT, 6'b000010), "dwl_stall");
    drv(0, 0, 0);
    chk(ex(LOAD_STALL, 6'b101000), "dwl_done");
    chk(ex(RUN, 6'b101000), "dwl_run");
  endtask
  task automatic test_reset_mid;
    drv(0, 1, 0);
    chk(ex(RUN, 6'b111110), "rmf_br");
    drv(0, 0, 0); reset = 1'b1;
    chk(ex(RUN, 6'b000100), "rmf_rst");
    reset = 1'b0;
    chk(ex(RUN, 6'b101000), "rmf_run");
    drv(1, 0, 0);
    chk(ex(RUN, 6'b000001), "rmw_frz");
    reset = 1'b1;
    chk(ex(RUN, 6'b000100), "rmw_rst");
    reset = 1'b0; drv(0, 0, 0);
    chk(ex(RUN, 6'b101000), "rmw_run");
  endtask
  task automatic test_saturate;
    drv(0, 0, 1);
    repeat (70000) @(negedge clk);
`ifdef HAZARD_PERF_EN
    m_stall = (32'(m_stall) + 70000 > 32'hFFFF) ? 16'hFFFF : m_stall + 16'(70000);
`endif
    chk(ex(LOAD_STALL, 6'b000010), "sat_hold");
    drv(0, 0, 0);
    chk(ex(LOAD_STALL, 6'b101000), "sat_end");
  endtask
  initial begin
    reset = 1'b1;
    drv(0, 0, 0);
    @(negedge clk);
    test_reset;
    test_load_use;
    test_no_hazard;
    test_restall;
    test_branch;
    test_back_to_back;
    test_dmem_branch;
    test_dmem_in_flush;
    test_dmem_load;
    test_reset_mid;
    test_saturate;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
